serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/shift_reg_right.sv | 33 +++
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t             : 2-bit sequencer encoding (IDLE/LOAD/SHIFT/DONE)
//   DEFAULT_BIT_WIDTH   : default operand/result width
//   DEFAULT_SIZE        : default bit-counter width (2^size > bit_width-1)
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int DEFAULT_BIT_WIDTH = 8;
    localparam int DEFAULT_SIZE      = 4;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor: computes a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/shift_reg_right.sv
// ---------------------------------------------------------------------------
// shift_reg_right
// Parameterised parallel-load / shift-right register.
//   clock      : rising-edge clock
//   reset      : synchronous active-high clear
//   load       : parallel load of load_data (has priority over shift)
//   shift      : shift right one bit, serial_in enters at the MSB
//   serial_in  : bit shifted into the MSB
//   load_data  : parallel load value
//   q          : register contents
// ---------------------------------------------------------------------------
module shift_reg_right #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             serial_in,
    input  logic [width-1:0] load_data,
    output logic [width-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_data;
        else if (shift)
            q <= {serial_in, q[width-1:1]};
    end

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: diff = ain - bin, one bit per clock, LSB first.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, aborts any operation
//   start   : request level, sampled in IDLE and DONE only
//   ain     : minuend (captured in the LOAD cycle)
//   bin     : subtrahend (captured in the LOAD cycle)
//   diff    : (ain - bin) mod 2^bit_width
//   borrow  : 1 iff ain < bin (unsigned)
//   ovf     : signed overflow of ain - bin
//   busy    : high in LOAD and SHIFT
//   done    : high in DONE; held while start stays high
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int bit_width = DEFAULT_BIT_WIDTH,
    parameter int size      = DEFAULT_SIZE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [bit_width-1:0] ain,
    input  logic [bit_width-1:0] bin,
    output logic [bit_width-1:0] diff,
    output logic                 borrow,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    state_t              state, state_next;
    logic [size-1:0]     cnt;
    logic                borrow_ff;
    logic                ovf_ff;
    logic                load_en, shift_en;
    logic [bit_width-1:0] a_q, b_q;
    logic                d_bit, bout_bit;
    logic                last_shift;

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // ---------------- sequencer: next-state ----------------
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:  state_next = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: state_next = (cnt == '0) ? ST_DONE : ST_SHIFT;
            // Holding in DONE while start stays high gives one op per pulse.
            ST_DONE:  state_next = start ? ST_DONE : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- sequencer: outputs ----------------
    always_comb begin
        load_en  = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_LOAD:  begin load_en  = 1'b1; busy = 1'b1; end
            ST_SHIFT: begin shift_en = 1'b1; busy = 1'b1; end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign last_shift = shift_en && (cnt == '0);

    // ---------------- datapath ----------------
    shift_reg_right #(.width(bit_width)) u_a_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load_en),
        .shift     (shift_en),
        .serial_in (1'b0),
        .load_data (ain),
        .q         (a_q)
    );

    shift_reg_right #(.width(bit_width)) u_b_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load_en),
        .shift     (shift_en),
        .serial_in (1'b0),
        .load_data (bin),
        .q         (b_q)
    );

    // Result bits enter at the MSB so after bit_width shifts the LSB lands at bit 0.
    shift_reg_right #(.width(bit_width)) u_diff_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load_en),
        .shift     (shift_en),
        .serial_in (d_bit),
        .load_data ({bit_width{1'b0}}),
        .q         (diff)
    );

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_ff),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            borrow_ff <= 1'b0;
            ovf_ff    <= 1'b0;
        end else if (load_en) begin
            cnt       <= size'(bit_width - 1);
            borrow_ff <= 1'b0;
        end else if (shift_en) begin
            cnt       <= cnt - size'(1);
            borrow_ff <= bout_bit;
            // On the sign-bit step: operand signs differ and the result
            // sign differs from the minuend's sign.
            if (last_shift)
                ovf_ff <= (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
        end
    end

    assign borrow = borrow_ff;
    assign ovf    = ovf_ff;

    // Only the LSBs of the operand registers feed the subtractor.
    logic unused_bits;
    assign unused_bits = ^{a_q[bit_width-1:1], b_q[bit_width-1:1]};

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int BW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] ain   = '0;
    logic [BW-1:0] bin   = '0;
    logic [BW-1:0] diff;
    logic          borrow, ovf, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [BW-1:0] diff;
        logic          borrow;
        logic          ovf;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } exp_t;

    exp_t sb_q[$];

    serial_subtractor #(.bit_width(BW), .size(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .ain    (ain),
        .bin    (bin),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= (1 << (BW-1))) ? ua - (1 << BW) : ua;
        sb = (ub >= (1 << (BW-1))) ? ub - (1 << BW) : ub;
        sd = sa - sb;
        e.diff   = BW'((ua - ub + (1 << BW)) % (1 << BW));
        e.borrow = (ua < ub);
        e.ovf    = (sd > (1 << (BW-1)) - 1) || (sd < -(1 << (BW-1)));
        e.a = a;
        e.b = b;
        return e;
    endfunction

    // Monitor: compares each completed result against the scoreboard head.
    initial begin
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge clock);
            if (done && !done_q) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("diff_%0h_%0h", e.a, e.b), 32'(diff), 32'(e.diff));
                    chk($sformatf("borrow_%0h_%0h", e.a, e.b), 32'(borrow), 32'(e.borrow));
                    chk($sformatf("ovf_%0h_%0h", e.a, e.b), 32'(ovf), 32'(e.ovf));
                end
            end
            done_q = done;
        end
    end

    // One operation. hold=1 keeps start high through DONE.
    // abort_at>0 asserts reset on that SHIFT edge instead of completing.
    task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input bit hold, input int abort_at);
        int n;
        logic [BW-1:0] d_snap;
        ain   = a;
        bin   = b;
        start = 1'b1;
        if (abort_at == 0) sb_q.push_back(model(a, b));
        @(posedge clock); #1;               // IDLE -> LOAD
        n = 1;
        if (!hold) start = 1'b0;
        @(posedge clock); #1;               // LOAD edge: operands captured
        n++;
        ain = BW'($urandom);                // must be ignored from here on
        bin = BW'($urandom);
        if (!hold) start = BW'($urandom) != 0 ? 1'b1 : 1'b0;  // ignored while busy
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clock);
            #1 reset = 1'b1;
            start = 1'b0;
            @(posedge clock); #1;
            reset = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_diff", 32'(diff), 32'd0);
            chk("abort_borrow", 32'(borrow), 32'd0);
            chk("abort_ovf", 32'(ovf), 32'd0);
            @(posedge clock); #1;
            chk("abort_idle_busy", 32'(busy), 32'd0);
            return;
        end
        while (!done && n < 40) begin
            if (!hold) start = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(BW + 2));
        if (hold) begin
            d_snap = diff;
            repeat (3) begin
                @(posedge clock); #1;
                chk("hold_done", 32'(done), 32'd1);
                chk("hold_busy", 32'(busy), 32'd0);
                chk("hold_diff", 32'(diff), 32'(d_snap));
            end
        end
        start = 1'b0;
        @(posedge clock); #1;
        chk("back_to_idle", 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(8'd100, 8'd37, 1'b0, 0);
        run_op(8'd5,   8'd10, 1'b0, 0);
        run_op(8'h80,  8'h01, 1'b0, 0);
        run_op(8'hFF,  8'h01, 1'b0, 4);   // abort on 4th SHIFT edge
        run_op(8'hFF,  8'h01, 1'b0, 0);
        run_op(8'hAA,  8'hAA, 1'b0, 0);
        run_op(8'h7F,  8'hFF, 1'b1, 0);   // start held through DONE
        run_op(8'h00,  8'hFF, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(BW'($urandom), BW'($urandom), ($urandom_range(0, 4) == 0), 0);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        repeat (4) @(posedge clock);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
